// File: rtl/mem_arbiter_ctrl.sv
// Memory-side arbiter: serves data and instruction cache requests on one RAM port.
// Data wins ties unless the instruction side has been passed over STARVE_LIMIT times.
module mem_arbiter_ctrl #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        tmo_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DSERV = 2'd1;
  localparam logic [1:0] ISERV = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [SW-1:0] r_starve_cnt;
  logic [SW-1:0] w_starve_next;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_tmo_err;

  logic w_d_req;
  logic w_access;
  logic w_d_live;
  logic w_i_live;
  logic w_waiting;
  logic w_starved;

  assign w_d_req   = dREN | dWEN;
  assign w_access  = (ramstate == RAM_ACCESS);
  // A serve state only drives the RAM while its requester still holds an enable.
  assign w_d_live  = (r_state == DSERV) && w_d_req;
  assign w_i_live  = (r_state == ISERV) && iREN;
  assign w_waiting = (w_d_live || w_i_live) && !w_access;
  assign w_starved = (r_starve_cnt == SW'(STARVE_LIMIT));

  assign tmo_err = r_tmo_err;

  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (w_d_live) begin
      ramaddr  = daddr;
      ramstore = dstore;
      ramREN   = dREN & ~dWEN;
      ramWEN   = dWEN;
      if (w_access) begin
        dwait = 1'b0;
        dload = ramload;
      end
    end
    if (w_i_live) begin
      ramaddr = iaddr;
      ramREN  = 1'b1;
      if (w_access) begin
        iwait = 1'b0;
        iload = ramload;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_d_req && iREN && w_starved) begin
          w_state_next = ISERV;
        end else if (w_d_req) begin
          w_state_next = DSERV;
        end else if (iREN) begin
          w_state_next = ISERV;
        end
      end
      DSERV: begin
        if (!w_d_req || w_access) begin
          w_state_next = IDLE;
        end
      end
      ISERV: begin
        if (!iREN || w_access) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_starve_next = r_starve_cnt;
    if (w_d_live && w_access) begin
      if (!iREN) begin
        w_starve_next = '0;
      end else if (!w_starved) begin
        w_starve_next = r_starve_cnt + 1'b1;
      end
    end
    if (w_i_live && w_access) begin
      w_starve_next = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_tmo_err    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
      // The counter saturates at TIMEOUT-1; the flag is sticky until reset.
      if (w_waiting) begin
        if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
          r_tmo_err <= 1'b1;
        end else begin
          r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end

endmodule
